// File: rtl/text_mode_generator.sv
// Text-mode renderer: holds one 14-bit cell word per character position in an
// internal buffer, looks glyph rows up in an external combinational font ROM
// and produces colour pixels with per-cell fg/bg colour, blink and a hardware
// cursor. Glyphs can be scaled by 2**SCALE_LOG2.
//
// Ports:
//   clock_in, reset_n_in          pixel clock, synchronous active-low reset
//   pixel_x/y_in, video_on_in,
//   h_sync_in, v_sync_in          timing from vga_sync
//   wr_en/addr/data_in            cell write port (addr = row*COLS+col)
//                                 data: [6:0] code, [7] blink, [10:8] fg, [13:11] bg
//   cursor_en/col/row_in          hardware cursor
//   char_line_in/char_address_out font ROM interface ({code, glyph_row})
//   pixel_out, video_on_out,
//   h_sync_out, v_sync_out        colour pixel and syncs, 3 cycles after input
//   busy_out                      buffer clear sweep in progress
module text_mode_generator #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 10,
  parameter int PIXEL_BITS   = 12,
  parameter int SCALE_LOG2   = 0,
  parameter int BLINK_FRAMES = 32,
  localparam int COLS      = WIDTH >> (3 + SCALE_LOG2),
  localparam int ROWS      = HEIGHT >> (4 + SCALE_LOG2),
  localparam int CELLS     = COLS * ROWS,
  localparam int ADDR_BITS = $clog2(CELLS)
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic [WIDTH_BITS-1:0]  pixel_x_in,
  input  logic [HEIGHT_BITS-1:0] pixel_y_in,
  input  logic                   video_on_in,
  input  logic                   h_sync_in,
  input  logic                   v_sync_in,
  input  logic                   wr_en_in,
  input  logic [ADDR_BITS-1:0]   wr_addr_in,
  input  logic [13:0]            wr_data_in,
  input  logic                   cursor_en_in,
  input  logic [ADDR_BITS-1:0]   cursor_col_in,
  input  logic [ADDR_BITS-1:0]   cursor_row_in,
  input  logic [7:0]             char_line_in,
  output logic [10:0]            char_address_out,
  output logic [PIXEL_BITS-1:0]  pixel_out,
  output logic                   video_on_out,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic                   busy_out
);

  localparam int STAGES = 3;
  localparam int CH     = PIXEL_BITS / 3;
  localparam int IDX_W  = WIDTH_BITS + HEIGHT_BITS + 1;
  localparam int BC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [13:0] BLANK_CELL = 14'h0720;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;

  // cell buffer write port (shared by the clear sweep and the user port)
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [13:0]          mem_wd;
  logic [13:0]          mem [CELLS];

  // stage 1
  logic [WIDTH_BITS-1:0]  col;
  logic [HEIGHT_BITS-1:0] row;
  logic [IDX_W-1:0]       rd_idx;
  logic [13:0]            cell_q, cell_d;
  logic [3:0]             grow_q, grow_d;
  logic [2:0]             bcol_q, bcol_d;
  logic                   hit_q, hit_d;
  // stage 2
  logic [7:0]             line_q, line_d;
  logic [6:0]             attr_q, attr_d;   // {bg[2:0], fg[2:0], blink}
  logic [2:0]             bcol2_q, bcol2_d;
  logic                   hit2_q, hit2_d;
  // stage 3
  logic                   glyph_on;
  logic [2:0]             fg, bg, rgb;
  logic [PIXEL_BITS-1:0]  pix_q, pix_d;
  // sync delay lines, index n = value n cycles after input
  logic [STAGES:1]        vid_pipe_q, vid_pipe_d;
  logic [STAGES:1]        hs_pipe_q, hs_pipe_d;
  logic [STAGES:1]        vs_pipe_q, vs_pipe_d;
  // blink
  logic                   vs_prev_q, vs_prev_d;
  logic [BC_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                   phase_q, phase_d;

  // ---------------- control FSM / buffer write ----------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;
    mem_wa  = wr_addr_in;
    mem_wd  = wr_data_in;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = ptr_q;
        mem_wd = BLANK_CELL;
        if (ptr_q == ADDR_BITS'(CELLS - 1)) state_d = ST_RUN;
        else                                ptr_d   = ptr_q + 1'b1;
      end
      default: begin
        // extra bit so the bound also works when CELLS is a power of two
        mem_we = wr_en_in && ({1'b0, wr_addr_in} < (ADDR_BITS + 1)'(CELLS));
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // ---------------- datapath ----------------
  always_comb begin
    col    = pixel_x_in >> (3 + SCALE_LOG2);
    row    = pixel_y_in >> (4 + SCALE_LOG2);
    rd_idx = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
    // positions outside the buffer (blanking) read as an empty word;
    // the write in the same cycle lands after the read, so old data is seen
    cell_d = (rd_idx < IDX_W'(CELLS)) ? mem[rd_idx[ADDR_BITS-1:0]] : '0;
    grow_d = 4'(pixel_y_in >> SCALE_LOG2);
    bcol_d = 3'(pixel_x_in >> SCALE_LOG2);
    hit_d  = (32'(col) == 32'(cursor_col_in)) && (32'(row) == 32'(cursor_row_in));

    line_d  = char_line_in;
    attr_d  = cell_q[13:7];
    bcol2_d = bcol_q;
    hit2_d  = hit_q;

    glyph_on = line_q[3'd7 - bcol2_q] && !(attr_q[0] && !phase_q);
    fg = attr_q[3:1];
    bg = attr_q[6:4];
    if (hit2_q && cursor_en_in && phase_q) begin
      fg = attr_q[6:4];
      bg = attr_q[3:1];
    end
    rgb   = glyph_on ? fg : bg;
    pix_d = '0;
    if (vid_pipe_q[STAGES-1] && state_q == ST_RUN)
      pix_d = PIXEL_BITS'({{CH{rgb[2]}}, {CH{rgb[1]}}, {CH{rgb[0]}}});

    vid_pipe_d = {vid_pipe_q[STAGES-1:1], video_on_in};
    hs_pipe_d  = {hs_pipe_q[STAGES-1:1], h_sync_in};
    vs_pipe_d  = {vs_pipe_q[STAGES-1:1], v_sync_in};
  end

  assign char_address_out = {cell_q[6:0], grow_q};

  // ---------------- blink timebase ----------------
  always_comb begin
    vs_prev_d   = v_sync_in;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (vs_prev_q && !v_sync_in) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      cell_q      <= '0;
      grow_q      <= '0;
      bcol_q      <= '0;
      hit_q       <= 1'b0;
      line_q      <= '0;
      attr_q      <= '0;
      bcol2_q     <= '0;
      hit2_q      <= 1'b0;
      pix_q       <= '0;
      vid_pipe_q  <= '0;
      hs_pipe_q   <= '1;
      vs_pipe_q   <= '1;
      vs_prev_q   <= 1'b1;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cell_q      <= cell_d;
      grow_q      <= grow_d;
      bcol_q      <= bcol_d;
      hit_q       <= hit_d;
      line_q      <= line_d;
      attr_q      <= attr_d;
      bcol2_q     <= bcol2_d;
      hit2_q      <= hit2_d;
      pix_q       <= pix_d;
      vid_pipe_q  <= vid_pipe_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      vs_prev_q   <= vs_prev_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign pixel_out    = pix_q;
  assign video_on_out = vid_pipe_q[STAGES];
  assign h_sync_out   = hs_pipe_q[STAGES];
  assign v_sync_out   = vs_pipe_q[STAGES];
  assign busy_out     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_text_mode_generator.sv
// Bench for text_mode_generator: two instances (scale 1 and scale 2) share the
// timing/write stimulus; a cell-array reference model predicts every pixel.
module tb_text_mode_generator;

  localparam int BF = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, von, hs, vs, we, cen;
  logic [9:0]  px, py;
  logic [11:0] wa0, cc0, cr0;
  logic [9:0]  wa1, cc1, cr1;
  logic [13:0] wd;
  logic [10:0] ca0, ca1;
  logic [7:0]  cl0, cl1;
  logic [11:0] pix0, pix1;
  logic        vo0, ho0, so0, busy0, vo1, ho1, so1, busy1;

  logic [7:0]  font [2048];
  assign cl0 = font[ca0];
  assign cl1 = font[ca1];

  text_mode_generator dut0 (
    .clock_in(clk), .reset_n_in(rst_n), .pixel_x_in(px), .pixel_y_in(py),
    .video_on_in(von), .h_sync_in(hs), .v_sync_in(vs),
    .wr_en_in(we), .wr_addr_in(wa0), .wr_data_in(wd),
    .cursor_en_in(cen), .cursor_col_in(cc0), .cursor_row_in(cr0),
    .char_line_in(cl0), .char_address_out(ca0), .pixel_out(pix0),
    .video_on_out(vo0), .h_sync_out(ho0), .v_sync_out(so0), .busy_out(busy0));

  text_mode_generator #(.SCALE_LOG2(1)) dut1 (
    .clock_in(clk), .reset_n_in(rst_n), .pixel_x_in(px), .pixel_y_in(py),
    .video_on_in(von), .h_sync_in(hs), .v_sync_in(vs),
    .wr_en_in(we), .wr_addr_in(wa1), .wr_data_in(wd),
    .cursor_en_in(cen), .cursor_col_in(cc1), .cursor_row_in(cr1),
    .char_line_in(cl1), .char_address_out(ca1), .pixel_out(pix1),
    .video_on_out(vo1), .h_sync_out(ho1), .v_sync_out(so1), .busy_out(busy1));

  typedef struct {
    logic [13:0] w0, w1;
    int gr0, gr1, bc0, bc1;
    bit hit0, hit1, von, hs, vs, cen;
    int falls, clr0, clr1;
  } ent_t;

  int n_cmp = 0, n_bad = 0;
  ent_t q[$];
  logic [13:0] cells0 [2400];
  logic [13:0] cells1 [600];
  int clr0, clr1, falls;
  bit vs_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_pix(input logic [13:0] w, input int gr, input int bc,
                                          input bit hit, input bit ph, input bit ce);
    logic [7:0] line;
    logic [2:0] f, b, c;
    bit on;
    line = font[w[6:0] * 16 + gr];
    on = line[7 - bc];
    if (w[7] && !ph) on = 0;
    f = w[10:8];
    b = w[13:11];
    if (hit && ce && ph) begin c = f; f = b; b = c; end
    c = on ? f : b;
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  // Called at a falling edge: checks outputs, drives one cycle of inputs,
  // records the expectation, then waits for the next falling edge.
  task automatic step(input int x, input int y, input bit v_on, input bit h_s, input bit v_s,
                      input bit w_en, input int a0, input int a1, input logic [13:0] d,
                      input bit c_en, input int c_c, input int c_r);
    ent_t e, e0, e1, e2;
    bit ph;
    check("busy0", busy0, clr0 > 0);
    check("busy1", busy1, clr1 > 0);
    if (q.size() > 0) begin
      e = q[$];
      if (e.clr0 <= 0) check("caddr0", ca0, {e.w0[6:0], 4'(e.gr0)});
      if (e.clr1 <= 0) check("caddr1", ca1, {e.w1[6:0], 4'(e.gr1)});
    end
    if (q.size() == 3) begin
      e0 = q.pop_front();
      e1 = q[0];
      e2 = q[1];
      ph = ((e1.falls / BF) % 2) == 0;
      check("von0", vo0, e0.von);  check("von1", vo1, e0.von);
      check("hs0", ho0, e0.hs);    check("hs1", ho1, e0.hs);
      check("vs0", so0, e0.vs);    check("vs1", so1, e0.vs);
      if (e2.clr0 > 0) check("pix0_clr", pix0, 0);
      else if (e0.clr0 <= 0)
        check("pix0", pix0, e0.von ? exp_pix(e0.w0, e0.gr0, e0.bc0, e0.hit0, ph, e2.cen) : 12'h0);
      if (e2.clr1 > 0) check("pix1_clr", pix1, 0);
      else if (e0.clr1 <= 0)
        check("pix1", pix1, e0.von ? exp_pix(e0.w1, e0.gr1, e0.bc1, e0.hit1, ph, e2.cen) : 12'h0);
    end
    px = 10'(x); py = 10'(y); von = v_on; hs = h_s; vs = v_s;
    we = w_en; wa0 = 12'(a0); wa1 = 10'(a1); wd = d;
    cen = c_en; cc0 = 12'(c_c); cr0 = 12'(c_r); cc1 = 10'(c_c); cr1 = 10'(c_r);
    e.w0 = cells0[(y / 16) * 80 + x / 8];
    e.gr0 = y % 16; e.bc0 = x % 8;
    e.hit0 = (x / 8 == c_c) && (y / 16 == c_r);
    e.w1 = cells1[(y / 32) * 40 + x / 16];
    e.gr1 = (y / 2) % 16; e.bc1 = (x / 2) % 8;
    e.hit1 = (x / 16 == c_c) && (y / 32 == c_r);
    if (vs_prev && !v_s) falls++;
    vs_prev = v_s;
    e.falls = falls; e.cen = c_en; e.von = v_on; e.hs = h_s; e.vs = v_s;
    e.clr0 = clr0; e.clr1 = clr1;
    q.push_back(e);
    if (w_en && clr0 <= 0 && a0 < 2400) cells0[a0] = d;
    if (w_en && clr1 <= 0 && a1 < 600)  cells1[a1] = d;
    clr0--; clr1--;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 0; von = 0; hs = 1; vs = 1; we = 0; cen = 0;
    repeat (cycles) @(negedge clk);
    check("rst_pix0", pix0, 0);  check("rst_pix1", pix1, 0);
    check("rst_von0", vo0, 0);   check("rst_von1", vo1, 0);
    check("rst_hs0", ho0, 1);    check("rst_vs0", so0, 1);
    check("rst_hs1", ho1, 1);    check("rst_vs1", so1, 1);
    check("rst_busy0", busy0, 1); check("rst_busy1", busy1, 1);
    rst_n = 1;
    q.delete();
    clr0 = 2400; clr1 = 600; falls = 0; vs_prev = 1;
    for (int i = 0; i < 2400; i++) cells0[i] = 14'h0720;
    for (int i = 0; i < 600; i++)  cells1[i] = 14'h0720;
  endtask

  initial begin
    int cnt, cnt1, cx, cy;
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
    for (int r = 0; r < 16; r++) font[32 * 16 + r] = 8'h00;
    rst_n = 0; px = 0; py = 0; von = 0; hs = 1; vs = 1; we = 0; wa0 = 0; wa1 = 0;
    wd = 0; cen = 0; cc0 = 0; cr0 = 0; cc1 = 0; cr1 = 0;
    @(negedge clk);
    do_reset(2);

    // clear sweep with writes that must be ignored
    cnt = 0; cnt1 = 0;
    while (busy0 && cnt < 5000) begin
      if (busy1) cnt1++;
      step($urandom_range(639), $urandom_range(479), 1, $urandom_range(1), 1,
           (cnt < 500) ? 1'($urandom_range(1)) : 1'b0, $urandom_range(2399),
           $urandom_range(599), 14'($urandom), 0, 0, 0);
      cnt++;
    end
    check("clear_len0", cnt, 2400);
    check("clear_len1", cnt1, 600);
    repeat (200) step($urandom_range(639), $urandom_range(479), 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // 'A' in cell 0, fg blue
    step(0, 0, 0, 1, 1, 1, 0, 0, 14'h0141, 0, 0, 0);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) step(x, y, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // blinking cell 1 across 65 frames
    step(0, 0, 0, 1, 1, 1, 1, 1, 14'h07C1, 0, 0, 0);
    for (int f = 0; f <= 64; f++) begin
      for (int x = 8; x < 16; x++) step(x, f % 16, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      if (f < 64) begin
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      end
    end

    // cursor on blank cell 0, then hidden after 32 frames
    step(0, 0, 0, 1, 1, 1, 0, 0, 14'h0720, 1, 0, 0);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) step(x, y, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    for (int f = 0; f < 32; f++) begin
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    end
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) step(x, y, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);

    // out-of-range addresses must not land anywhere
    step(0, 0, 0, 1, 1, 1, 2400, 1000, 14'h3FFF, 0, 0, 0);
    for (int x = 0; x < 640; x++) step(x, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cx = $urandom_range(39); cy = $urandom_range(14);
      if ($urandom_range(3) == 0)
        step(cx * 8 + $urandom_range(7), cy * 16 + $urandom_range(15),
             ($urandom_range(7) != 0), $urandom_range(1), ($urandom_range(15) != 0),
             $urandom_range(1), $urandom_range(2599), $urandom_range(1023),
             14'($urandom), ($urandom_range(3) != 0), cx, cy);
      else
        step($urandom_range(639), $urandom_range(479),
             ($urandom_range(7) != 0), $urandom_range(1), ($urandom_range(15) != 0),
             $urandom_range(1), $urandom_range(2599), $urandom_range(1023),
             14'($urandom), ($urandom_range(3) != 0), cx, cy);
    end

    // reset in the middle of a sweep restarts it
    do_reset(1);
    repeat (1000) step($urandom_range(639), $urandom_range(479), 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    do_reset(1);
    cnt = 0;
    while (busy0 && cnt < 5000) begin
      step($urandom_range(639), $urandom_range(479), 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      cnt++;
    end
    check("resweep_len", cnt, 2400);
    repeat (50) step($urandom_range(639), $urandom_range(479), 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/text_mode_generator.md
Name: text_mode_generator

Overview:
- Parametrised successor to character_generator: a full text-mode renderer with an internal character buffer (one cell word per character position).
- Per-cell foreground/background colour, blink attribute, hardware cursor and integer glyph scaling.
- Sits between vga_sync and the pixel sink; drives the external combinational font_rom; outputs colour pixels with re-aligned sync/video_on.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
WIDTH_BITS, 10, pixel_x width
HEIGHT_BITS, 10, pixel_y width
PIXEL_BITS, 12, output colour width (4 bits each R,G,B)
SCALE_LOG2, 0, glyph scale = 2**SCALE_LOG2 (0..2); cell = 8*scale x 16*scale pixels
BLINK_FRAMES, 32, frames per blink half-period (>=1)
Derived (localparam): COLS = WIDTH>>(3+SCALE_LOG2); ROWS = HEIGHT>>(4+SCALE_LOG2); CELLS = COLS*ROWS; ADDR_BITS = clog2(CELLS).

Ports:
clock_in  in  1  pixel clock
reset_n_in  in  1  synchronous active-low reset
pixel_x_in  in  WIDTH_BITS  current x from vga_sync
pixel_y_in  in  HEIGHT_BITS  current y from vga_sync
video_on_in  in  1  display_on from vga_sync
h_sync_in  in  1  h_sync from vga_sync (active low)
v_sync_in  in  1  v_sync from vga_sync (active low)
wr_en_in  in  1  cell write strobe
wr_addr_in  in  ADDR_BITS  cell index = row*COLS+col
wr_data_in  in  14  cell word: [6:0] code, [7] blink, [10:8] fg RGB, [13:11] bg RGB
cursor_en_in  in  1  cursor enable
cursor_col_in  in  ADDR_BITS  cursor column
cursor_row_in  in  ADDR_BITS  cursor row
char_line_in  in  8  font_rom data
char_address_out  out  11  font_rom address = {code, glyph_row[3:0]}
pixel_out  out  PIXEL_BITS  colour
video_on_out, h_sync_out, v_sync_out  out  1 each  syncs delayed to match pixel_out
busy_out  out  1  clear sweep in progress

Behaviour:
- FSM CLEAR/RUN. Reset (reset_n_in=0 at posedge) -> CLEAR, clear pointer=0, blink counter=0, phase=1, all pipeline regs 0; pixel_out=0, video_on_out=0, h_sync_out=1, v_sync_out=1, busy_out=1.
- CLEAR: writes 14'h0720 (space, fg white, bg black, no blink) to address ptr each cycle; ptr==CELLS-1 -> RUN next cycle. Takes exactly CELLS cycles. User writes ignored; pixel_out forced 0; syncs still pipelined. Reset mid-sweep restarts from 0.
- RUN: wr_en_in writes wr_data_in at wr_addr_in; wr_addr_in>=CELLS ignored. Write and read of the same address in one cycle: read returns old word.
- Pipeline, latency 3 cycles from coordinate input to pixel_out:
  S1: col=pixel_x>>(3+SCALE_LOG2), row=pixel_y>>(4+SCALE_LOG2); synchronous RAM read of row*COLS+col. Register glyph_row=(pixel_y>>SCALE_LOG2)[3:0], bit_col=(pixel_x>>SCALE_LOG2)[2:0], cursor hit, video_on.
  S2: char_address_out={code, glyph_row} (combinational from S1 regs). Register char_line_in, attributes, bit_col, cursor hit.
  S3: glyph bit=line[7-bit_col] (MSB leftmost). Hidden if blink=1 and phase=0. Cursor hit and cursor_en_in and phase=1 -> swap fg/bg. Colour channel = {4{rgb bit}}, R=[2]. pixel_out = delayed video_on ? colour : 0.
- video_on_out/h_sync_out/v_sync_out: video_on_in/h_sync_in/v_sync_in delayed 3 cycles.
- Blink: each v_sync_in falling edge increments counter. At BLINK_FRAMES-1 it wraps to 0 and phase toggles.

Test Plan:
- Reset, SCALE_LOG2=0 -> busy_out=1 for exactly 2400 cycles; all visible pixels then 12'h000; writes during busy have no effect.
- Write cell 0=14'h0141 ('A', fg blue, bg black); drive (x=0..7, y=0..15) -> char_address_out=0x410..0x41F; pixel_out=12'h00F where font_rom bit set else 12'h000, 3 cycles after input.
- Cursor at (0,0), cursor_en_in=1, cell word 14'h0720 -> cell fills 12'hFFF. After 32 v_sync falling edges -> 12'h000.
- Cell 1 word 14'h07C1 (blink) -> glyph visible frames 0-31, hidden 32-63, visible at frame 64.
- SCALE_LOG2=1 -> COLS=40, each font bit spans 2x2 pixels; wr_addr_in=1200 ignored.
- Assert reset mid-sweep at ptr=1000 -> sweep restarts, busy_out low after 2400 more cycles.
